// File: rtl/drac_pkg.sv
// Shared DRAC tile constants and types for the HPM event path.
// Holds event counts and widths used as defaults by hpm_event_hub.
package drac_pkg;

    localparam int HPM_NUM_EVENTS = 40;
    localparam int HPM_EXT_INC_W  = 2;
    localparam int HPM_EXT_PEND_W = 6;

    typedef logic [HPM_EXT_INC_W-1:0] hpm_ext_inc_t;

endpackage

// File: rtl/hpm_ext_drain.sv
// One external HPM event: pending counter, saturation, sticky loss flag.
// Ports: clk_i, tile_rstn, inc_i, gate_i, lost_clr_i -> event_o, lost_o, busy_o.
module hpm_ext_drain
    import drac_pkg::*;
#(
    parameter int INC_W  = HPM_EXT_INC_W,
    parameter int PEND_W = HPM_EXT_PEND_W
) (
    input  logic             clk_i,
    input  logic             tile_rstn,
    input  logic [INC_W-1:0] inc_i,
    input  logic             gate_i,
    input  logic             lost_clr_i,
    output logic             event_o,
    output logic             lost_o,
    output logic             busy_o
);

    localparam logic [PEND_W:0] SAT = {1'b0, {PEND_W{1'b1}}};

    logic [PEND_W-1:0] p_q;
    logic [PEND_W-1:0] p_d;
    logic              lost_q;
    logic              lost_d;
    logic              ev_q;
    logic              ev_d;

    logic [INC_W-1:0]  inc_eff;
    logic [PEND_W:0]   total;
    logic [PEND_W:0]   nxt;
    logic              sat;

    // While gated, incoming counts are discarded (not lost) and
    // the pending count is frozen because drain is also held off.
    always_comb begin
        inc_eff = gate_i ? '0 : inc_i;
        total   = {1'b0, p_q} + {{(PEND_W + 1 - INC_W){1'b0}}, inc_eff};
        ev_d    = (total != '0) && !gate_i;
        nxt     = total - {{PEND_W{1'b0}}, ev_d};
        sat     = nxt > SAT;
        p_d     = sat ? SAT[PEND_W-1:0] : nxt[PEND_W-1:0];
        // Set has priority over a coincident clear.
        lost_d  = sat | (lost_q & ~lost_clr_i);
    end

    always_ff @(posedge clk_i or negedge tile_rstn) begin
        if (!tile_rstn) begin
            p_q    <= '0;
            lost_q <= 1'b0;
            ev_q   <= 1'b0;
        end else begin
            p_q    <= p_d;
            lost_q <= lost_d;
            ev_q   <= ev_d;
        end
    end

    assign event_o = ev_q;
    assign lost_o  = lost_q;
    // p_q is the registered next-state, so this is a registered flag.
    assign busy_o  = (p_q != '0);

endmodule

// File: rtl/hpm_event_hub.sv
// HPM event conditioning: registers core strobes, drains uncore bursts.
// Ports: clk_i, tile_rstn, int_events_i, ext_inc_i, debug_halted_i,
// lost_clr_i -> events_o, ext_lost_o, ext_busy_o.
// Optional: DEBUG_STOPCOUNT_EN stops counting while debug_halted_i.
module hpm_event_hub
    import drac_pkg::*;
#(
    parameter int NUM_INT_EVENTS = HPM_NUM_EVENTS,
    parameter int NUM_EXT_EVENTS = 4,
    parameter int INC_W          = HPM_EXT_INC_W,
    parameter int PEND_W         = HPM_EXT_PEND_W
) (
    input  logic                                   clk_i,
    input  logic                                   tile_rstn,
    input  logic [NUM_INT_EVENTS:1]                int_events_i,
    input  logic [NUM_EXT_EVENTS*INC_W-1:0]        ext_inc_i,
    input  logic                                   debug_halted_i,
    input  logic                                   lost_clr_i,
    output logic [NUM_INT_EVENTS+NUM_EXT_EVENTS:1] events_o,
    output logic [NUM_EXT_EVENTS-1:0]              ext_lost_o,
    output logic                                   ext_busy_o
);

    logic                      gate;
    logic [NUM_INT_EVENTS:1]   int_q;
    logic [NUM_INT_EVENTS:1]   int_d;
    logic [NUM_EXT_EVENTS-1:0] ext_ev;
    logic [NUM_EXT_EVENTS-1:0] ext_busy;

`ifdef DEBUG_STOPCOUNT_EN
    assign gate = debug_halted_i;
`else
    logic unused_debug_halted;
    assign unused_debug_halted = debug_halted_i;
    assign gate = 1'b0;
`endif

    always_comb begin
        int_d = gate ? '0 : int_events_i;
    end

    always_ff @(posedge clk_i or negedge tile_rstn) begin
        if (!tile_rstn) begin
            int_q <= '0;
        end else begin
            int_q <= int_d;
        end
    end

    for (genvar j = 0; j < NUM_EXT_EVENTS; j++) begin : g_ext
        hpm_ext_drain #(
            .INC_W  (INC_W),
            .PEND_W (PEND_W)
        ) u_drain (
            .clk_i      (clk_i),
            .tile_rstn  (tile_rstn),
            .inc_i      (ext_inc_i[j*INC_W +: INC_W]),
            .gate_i     (gate),
            .lost_clr_i (lost_clr_i),
            .event_o    (ext_ev[j]),
            .lost_o     (ext_lost_o[j]),
            .busy_o     (ext_busy[j])
        );
    end

    assign events_o   = {ext_ev, int_q};
    assign ext_busy_o = |ext_busy;

endmodule

// File: tb/tb_hpm_event_hub.sv
// Randomized and directed bench for hpm_event_hub with a counting model.
// Honors DEBUG_STOPCOUNT_EN the same way the design build does.
module tb_hpm_event_hub;

    localparam int NI = 40;
    localparam int NE = 4;
    localparam int IW = 2;
    localparam int PMAX = 63;

    logic             clk_i = 1'b0;
    logic             tile_rstn = 1'b0;
    logic [NI:1]      int_events_i = '0;
    logic [NE*IW-1:0] ext_inc_i = '0;
    logic             debug_halted_i = 1'b0;
    logic             lost_clr_i = 1'b0;
    logic [NI+NE:1]   events_o;
    logic [NE-1:0]    ext_lost_o;
    logic             ext_busy_o;

    int checks = 0;
    int errors = 0;

    int pend [NE];
    bit lost [NE];
    logic [NI+NE:1] exp_ev;
    logic [NE-1:0]  exp_lost;
    logic           exp_busy;

    hpm_event_hub dut (
        .clk_i          (clk_i),
        .tile_rstn      (tile_rstn),
        .int_events_i   (int_events_i),
        .ext_inc_i      (ext_inc_i),
        .debug_halted_i (debug_halted_i),
        .lost_clr_i     (lost_clr_i),
        .events_o       (events_o),
        .ext_lost_o     (ext_lost_o),
        .ext_busy_o     (ext_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < NE; j++) begin
            pend[j] = 0;
            lost[j] = 0;
        end
        exp_ev = '0;
        exp_lost = '0;
        exp_busy = 1'b0;
    endtask

    // Counting model: each event owns an integer backlog that receives
    // inc and gives back one count per cycle, capped at PMAX.
    task automatic model_step(input logic [NI:1] ie, input logic [NE*IW-1:0] inc,
                              input logic dh, input logic clr);
        bit g;
        int a;
        int t;
        bit d;
        bit s;
`ifdef DEBUG_STOPCOUNT_EN
        g = dh;
`else
        g = 1'b0;
`endif
        exp_ev[NI:1] = g ? '0 : ie;
        exp_busy = 1'b0;
        for (int j = 0; j < NE; j++) begin
            a = g ? 0 : int'(inc[j*IW +: IW]);
            t = pend[j] + a;
            d = (t > 0) && !g;
            t = t - (d ? 1 : 0);
            s = t > PMAX;
            pend[j] = s ? PMAX : t;
            if (clr) lost[j] = 0;
            if (s) lost[j] = 1;
            exp_ev[NI+1+j] = d;
            exp_lost[j] = lost[j];
            if (pend[j] != 0) exp_busy = 1'b1;
        end
    endtask

    task automatic cyc(input logic [NI:1] ie, input logic [NE*IW-1:0] inc,
                       input logic dh, input logic clr);
        int_events_i = ie;
        ext_inc_i = inc;
        debug_halted_i = dh;
        lost_clr_i = clr;
        @(posedge clk_i);
        #1;
        model_step(ie, inc, dh, clr);
        check("events", 64'(events_o), 64'(exp_ev));
        check("lost", 64'(ext_lost_o), 64'(exp_lost));
        check("busy", 64'(ext_busy_o), 64'(exp_busy));
    endtask

    task automatic idle();
        cyc('0, '0, 1'b0, 1'b0);
    endtask

    int cnt;
    int bcnt;
    logic [63:0] r;

    initial begin
        model_reset();
        #12;
        check("rst_events", 64'(events_o), 64'd0);
        check("rst_lost", 64'(ext_lost_o), 64'd0);
        check("rst_busy", 64'(ext_busy_o), 64'd0);
        @(negedge clk_i);
        tile_rstn = 1'b1;
        idle();

        // Single internal pulse appears for exactly one cycle.
        cyc(40'h1, '0, 1'b0, 1'b0);
        check("pulse_hit", 64'(events_o), 64'd1);
        idle();
        check("pulse_gone", 64'(events_o), 64'd0);

        // Burst of 3 on event 0 -> three drain cycles, busy for two.
        cyc('0, 8'h03, 1'b0, 1'b0);
        cnt = 1;
        bcnt = ext_busy_o ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (events_o[41]) cnt++;
            if (ext_busy_o) bcnt++;
        end
        check("burst_cnt", 64'(cnt), 64'd3);
        check("burst_busy", 64'(bcnt), 64'd2);

        // Saturation: 40 cycles of inc=3, then exactly 63 drains.
        for (int i = 0; i < 40; i++) cyc('0, 8'h03, 1'b0, 1'b0);
        check("sat_lost", 64'(ext_lost_o), 64'd1);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            idle();
            if (events_o[41]) cnt++;
        end
        check("sat_drain_cnt", 64'(cnt), 64'd63);
        check("sat_lost_sticky", 64'(ext_lost_o), 64'd1);

        // Clear race: set wins over coincident clear.
        cyc('0, '0, 1'b0, 1'b1);
        check("clr_alone", 64'(ext_lost_o), 64'd0);
        for (int i = 0; i < 31; i++) cyc('0, 8'h03, 1'b0, 1'b0);
        check("pre_race", 64'(ext_lost_o), 64'd0);
        cyc('0, 8'h03, 1'b0, 1'b1);
        check("race_set_wins", 64'(ext_lost_o), 64'd1);
        cyc('0, '0, 1'b0, 1'b1);
        check("clr_after", 64'(ext_lost_o), 64'd0);
        for (int i = 0; i < 70; i++) idle();

        // Debug halt with 5 pending on event 0.
        cyc('0, 8'h03, 1'b0, 1'b0);
        cyc('0, 8'h03, 1'b0, 1'b0);
        cyc('0, 8'h02, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            r = {$urandom(), $urandom()};
            cyc(r[NI-1:0] | 40'h1, 8'hAA, 1'b1, 1'b0);
            if (events_o != '0) cnt++;
        end
`ifdef DEBUG_STOPCOUNT_EN
        check("halt_quiet", 64'(cnt), 64'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            idle();
            if (events_o[41]) cnt++;
        end
        check("halt_resume", 64'(cnt), 64'd5);
`else
        check("halt_counts", 64'(cnt), 64'd10);
        for (int i = 0; i < 70; i++) idle();
`endif
        check("halt_no_lost", 64'(ext_lost_o), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            r = {$urandom(), $urandom()};
            cyc(r[NI-1:0], r[47:40] & (i % 64 < 40 ? 8'hFF : 8'h55),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 20) == 0));
        end
        for (int i = 0; i < 70; i++) idle();

        // Reset mid-burst with 20 pending.
        for (int i = 0; i < 10; i++) cyc('0, 8'h03, 1'b0, 1'b0);
        #2;
        tile_rstn = 1'b0;
        #1;
        model_reset();
        check("mid_rst_events", 64'(events_o), 64'd0);
        check("mid_rst_lost", 64'(ext_lost_o), 64'd0);
        check("mid_rst_busy", 64'(ext_busy_o), 64'd0);
        @(negedge clk_i);
        tile_rstn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            idle();
            if (events_o != '0) cnt++;
        end
        check("post_rst_quiet", 64'(cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
